// File: rtl/pmem_responder_if.sv
// pmem_responder_if: line-level physical-memory bus between requester and memory.
// Requester drives read/write/address/wdata; memory returns resp/rdata/protocol_error.
interface pmem_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         protocol_error;

  modport master (
    output pmem_read,
    output pmem_write,
    output pmem_address,
    output pmem_wdata,
    input  pmem_resp,
    input  pmem_rdata,
    input  protocol_error
  );

  modport slave (
    input  pmem_read,
    input  pmem_write,
    input  pmem_address,
    input  pmem_wdata,
    output pmem_resp,
    output pmem_rdata,
    output protocol_error
  );
endinterface

// File: rtl/pmem_responder.sv
// pmem_responder: 128-bit line memory, one request at a time, LATENCY-cycle service.
// Ports: clk, reset (async, active-high), pmem (slave side of pmem_responder_if).
module pmem_responder #(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  pmem_responder_if.slave   pmem
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [INDEX_BITS-1:0]   idx_q, idx_d;
  logic [127:0]            wdata_q, wdata_d;
  logic                    wr_q, wr_d;
  logic [127:0]            rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    mem_we;

  // Contents are deliberately not reset.
  logic [127:0]            line_mem [LINES];

  // Offset and aliased upper address bits have no effect.
  logic                    unused_addr;
  assign unused_addr = ^pmem.pmem_address;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pmem.pmem_read || pmem.pmem_write) begin
          idx_d   = pmem.pmem_address[INDEX_BITS+3:4];
          wdata_d = pmem.pmem_wdata;
          wr_d    = pmem.pmem_write;
          cnt_d   = 8'(LATENCY - 1);
          state_d = BUSY;
          if (pmem.pmem_read && pmem.pmem_write)
            err_d = 1'b1;
        end
      end
      BUSY: begin
        // Withdrawn request: flag it, but still finish.
        if (!pmem.pmem_read && !pmem.pmem_write)
          err_d = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d = RESP;
          if (wr_q)
            mem_we = 1'b1;
          else
            rdata_d = line_mem[idx_q];
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // mem_we is only ever set in BUSY, which reset forces away.
  always_ff @(posedge clk) begin
    if (mem_we)
      line_mem[idx_q] <= wdata_q;
  end

  assign pmem.pmem_resp      = (state_q == RESP);
  assign pmem.pmem_rdata     = rdata_q;
  assign pmem.protocol_error = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: vector table plus corner sequences for pmem_responder.
// Two DUTs: LATENCY=4 (main) and LATENCY=1 (short-latency corner).
module tb_pmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pmem_responder_if bus ();
  pmem_responder_if bus1 ();

  pmem_responder #(.LATENCY(4), .INDEX_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .pmem  (bus.slave)
  );

  pmem_responder #(.LATENCY(1), .INDEX_BITS(8)) dut1 (
    .clk   (clk),
    .reset (reset),
    .pmem  (bus1.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [127:0] sb [$];

  localparam logic [127:0] D1 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] DA = {8{16'hAAAA}};
  localparam logic [127:0] D5 = {8{16'h5555}};
  localparam logic [127:0] DP = 128'hDEADBEEF_00112233_44556677_CAFEF00D;
  localparam logic [127:0] DX = 128'h1230_1230_0000_FFFF_1111_2222_3333_4444;
  localparam logic [127:0] DQ = 128'h0300_0300_0300_0300_0300_0300_0300_0300;
  localparam logic [127:0] DR = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
  localparam logic [127:0] DF = {128{1'b1}};
  localparam logic [127:0] DZ = 128'h7777_0000_1234_5678_9ABC_DEF0_0F0F_F0F0;

  typedef struct {
    bit           rd;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [15:0] addr, input logic [127:0] wd);
    if (sel) begin
      bus1.pmem_read = rd;
      bus1.pmem_write = wr;
      bus1.pmem_address = addr;
      bus1.pmem_wdata = wd;
    end else begin
      bus.pmem_read = rd;
      bus.pmem_write = wr;
      bus.pmem_address = addr;
      bus.pmem_wdata = wd;
    end
  endtask

  function automatic logic get_resp(input bit sel);
    return sel ? bus1.pmem_resp : bus.pmem_resp;
  endfunction

  function automatic logic [127:0] get_rdata(input bit sel);
    return sel ? bus1.pmem_rdata : bus.pmem_rdata;
  endfunction

  function automatic logic get_err(input bit sel);
    return sel ? bus1.protocol_error : bus.protocol_error;
  endfunction

  // One transaction; latency counted in negedges after the accept edge.
  task automatic op(input bit sel, input bit rd, input bit wr,
                    input logic [15:0] addr, input logic [127:0] wd,
                    input bit drop_early, input int exp_lat,
                    input logic [127:0] exp_rd, input string name);
    int lat;
    bit seen;
    logic [127:0] e;
    @(posedge clk);
    #1 drive(sel, rd, wr, addr, wd);
    sb.push_back(exp_rd);
    @(posedge clk);
    seen = 1'b0;
    lat = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 0 && drop_early)
        drive(sel, 1'b0, 1'b0, addr, wd);
      if (get_resp(sel)) begin
        seen = 1'b1;
        lat = k;
      end
    end
    check({name, " resp_seen"}, 128'(seen), 128'd1);
    check({name, " latency"}, 128'(lat), 128'(exp_lat));
    e = sb.pop_front();
    check({name, " rdata"}, get_rdata(sel), e);
    drive(sel, 1'b0, 1'b0, addr, wd);
    @(negedge clk);
    check({name, " one_pulse"}, 128'(get_resp(sel)), 128'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int hits [2];
    int nhit;
    bit seen;

    vecs[0] = '{0, 1, 16'h0040, D1, 128'd0};
    vecs[1] = '{1, 0, 16'h004F, 128'd0, D1};
    vecs[2] = '{0, 1, 16'h0100, DA, D1};
    vecs[3] = '{0, 1, 16'h1100, D5, D1};
    vecs[4] = '{1, 0, 16'h0100, 128'd0, D5};
    vecs[5] = '{0, 1, 16'h0500, DP, D5};
    vecs[6] = '{1, 0, 16'h0040, 128'd0, D1};
    vecs[7] = '{1, 0, 16'h0508, 128'd0, DP};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 128'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 128'd0);
    repeat (3) @(negedge clk);
    check("rst resp", 128'(bus.pmem_resp), 128'd0);
    check("rst rdata", bus.pmem_rdata, 128'd0);
    check("rst err", 128'(bus.protocol_error), 128'd0);
    check("rst resp1", 128'(bus1.pmem_resp), 128'd0);
    reset = 1'b0;

    foreach (vecs[i])
      op(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
         1'b0, 4, vecs[i].exp_rdata, $sformatf("vec%0d", i));
    check("vec err", 128'(bus.protocol_error), 128'd0);

    // Read held through two completions: pulses 7 cycles apart.
    op(1'b0, 1'b0, 1'b1, 16'h1230, DX, 1'b0, 4, DP, "hold_wr");
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 1'b0, 16'h1230, 128'd0);
    @(posedge clk);
    nhit = 0;
    for (int k = 0; k < 40 && nhit < 2; k++) begin
      @(negedge clk);
      if (bus.pmem_resp) begin
        hits[nhit] = k;
        nhit++;
        check("hold rdata", bus.pmem_rdata, DX);
        if (nhit == 2)
          drive(1'b0, 1'b0, 1'b0, 16'h1230, 128'd0);
      end
    end
    check("hold pulses", 128'(nhit), 128'd2);
    check("hold first", 128'(hits[0]), 128'd4);
    check("hold gap", 128'(hits[1] - hits[0]), 128'd7);
    @(negedge clk);
    check("hold one_pulse", 128'(bus.pmem_resp), 128'd0);
    check("hold err", 128'(bus.protocol_error), 128'd0);

    // Reset mid-write discards the write.
    op(1'b0, 1'b0, 1'b1, 16'h0300, DQ, 1'b0, 4, DX, "pre_wr");
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b1, 16'h0300, DR);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midrst resp", 128'(bus.pmem_resp), 128'd0);
    check("midrst rdata", bus.pmem_rdata, 128'd0);
    drive(1'b0, 1'b0, 1'b0, 16'h0300, DR);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.pmem_resp)
        seen = 1'b1;
    end
    check("midrst no_resp", 128'(seen), 128'd0);
    op(1'b0, 1'b1, 1'b0, 16'h0300, 128'd0, 1'b0, 4, DQ, "post_rst_rd");

    // Both strobes at accept: serviced as write, sticky error.
    check("err clear", 128'(bus.protocol_error), 128'd0);
    op(1'b0, 1'b1, 1'b1, 16'h0200, DF, 1'b0, 4, DQ, "both");
    check("both err", 128'(bus.protocol_error), 128'd1);
    op(1'b0, 1'b1, 1'b0, 16'h0200, 128'd0, 1'b0, 4, DF, "both_rd");
    op(1'b0, 1'b1, 1'b0, 16'h0040, 128'd0, 1'b0, 4, D1, "legal_rd");
    check("both sticky", 128'(bus.protocol_error), 128'd1);
    pulse_reset();
    check("err rst", 128'(bus.protocol_error), 128'd0);

    // Withdrawn request still completes; LATENCY=4 then LATENCY=1.
    op(1'b0, 1'b1, 1'b0, 16'h0040, 128'd0, 1'b1, 4, D1, "drop4");
    check("drop4 err", 128'(bus.protocol_error), 128'd1);
    check("lat1 err0", 128'(bus1.protocol_error), 128'd0);
    op(1'b1, 1'b0, 1'b1, 16'h0010, DZ, 1'b1, 1, 128'd0, "drop1_wr");
    check("drop1 err", 128'(bus1.protocol_error), 128'd1);
    op(1'b1, 1'b1, 1'b0, 16'h0010, 128'd0, 1'b0, 1, DZ, "lat1_rd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
